sfp_event_decoder: RTL and testbench
====================================

// Module: sfp_event_decoder
// PURPOSE
//  Parametrised event decoder behind the SFP GTX receiver. Decodes the 8b/10b event byte
//  into NUM_EVENTS stretched, individually programmable event pulses. Rebuilds the 32-bit
//  seconds timestamp from 0x70/0x71 bit codes and monitors the 0x7A heartbeat. Passes
//  through the distributed-bus byte. Sits between the GTX wrapper and the PandA bit bus.
// PARAMETERS
//  NUM_EVENTS  4      number of event output channels (1..16)
//  PULSE_LEN   4      event pulse width in clk_i cycles (>=1); retrigger reloads
//  HB_TIMEOUT  8192   cycles without 0x7A before heartbeat_lost_o asserts
//  CNT_W       16     width of per-channel hit counters (optional feature)
// PORTS
//  clk_i          in   1             system/recovered clock
//  reset_i        in   1             synchronous, active-high reset
//  rxdata_i       in   16            [7:0] event byte, [15:8] distributed bus
//  rxcharisk_i    in   2             K-char flags; [0] qualifies the event byte
//  rx_link_ok_i   in   1             link aligned and error free
//  event_code_i   in   8*NUM_EVENTS  code per channel, ch n at [8n+7:8n]; 0 = disabled
//  event_o        out  NUM_EVENTS    stretched event pulses
//  dbus_o         out  8             registered rxdata_i[15:8]
//  utime_o        out  32            last complete seconds value
//  utime_valid_o  out  1             high once a valid 32-bit timestamp is latched
//  sec_err_o      out  1             1-cycle pulse: 0x7D seen with bit count != 32
//  heartbeat_lost_o out 1            heartbeat watchdog expired
//  event_cnt_o    out  CNT_W*NUM_EVENTS  per-channel hit counters (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, shift reg/bit count/watchdog/stretch counters cleared.
//  - Valid byte: rx_link_ok_i=1, rxcharisk_i[0]=0, rxdata_i[7:0]!=0. Sampled on edge N.
//  - Event match: valid byte == event_code_i[ch] and code != 0. event_o[ch]=1 from edge N+1
//    for exactly PULSE_LEN cycles. A match while stretching reloads the counter, so no gap.
//    Multiple channels with the same code fire together.
//  - Reserved codes 0x70/0x71/0x7A/0x7D still drive event outputs if programmed.
//  - Seconds: 0x70 shifts in 0 and 0x71 shifts in 1, MSB first (shreg <= {shreg[30:0],b}).
//    The bit count saturates at 33.
//  - 0x7D with count==32: utime_o <= shreg on edge N+1 and utime_valid_o <= 1.
//    0x7D with count!=32: utime_o is held and sec_err_o pulses at N+1.
//    Both cases clear shreg and the count.
//  - Heartbeat: 16-bit watchdog increments each cycle; 0x7A clears it to 0.
//    heartbeat_lost_o=1 while count >= HB_TIMEOUT. The counter saturates there, no wrap.
//  - dbus_o <= rxdata_i[15:8] when link ok, else 0; latency 1.
//  - Link drop (rx_link_ok_i=0): event_o forced 0 next cycle, stretch counters, shreg and
//    count cleared, utime_valid_o cleared. utime_o is held and the watchdog keeps running.
//  - event_code_i may change at any time; it takes effect on the next sampled byte and
//    does not cut a pulse already running.
// CONFIGURATION
//  SFP_EVENT_CNT_EN defined: each channel has a CNT_W-bit counter that increments on
//    every match and saturates at all-ones. It is cleared by reset_i only and is
//    presented on event_cnt_o.
//  Undefined: no counter logic; event_cnt_o tied to 0.
// TESTING
//  1 ch0=0x7C, PULSE_LEN=4, single 0x7C -> event_o[0] high exactly 4 cycles from N+1.
//  2 0x7C at N and N+2 -> event_o[0] continuous 6 cycles; code 0 on all ch -> event_o stays 0.
//  3 32 bits encoding 0xA5A5_0001 then 0x7D -> utime_o=0xA5A50001, utime_valid_o=1 at N+1.
//  4 31 bits then 0x7D -> sec_err_o 1-cycle pulse, utime_o unchanged; 33 bits -> same.
//  5 No 0x7A for 8192 cycles -> heartbeat_lost_o=1; one 0x7A -> 0 next cycle.
//  6 rx_link_ok_i low mid-pulse and mid-shift -> event_o=0 next cycle; next 32 bits + 0x7D
//    latch cleanly.
//    With SFP_EVENT_CNT_EN and CNT_W=4: 20 matches -> event_cnt_o[3:0]=0xF.

Source files
------------

// File: rtl/sfp_event_decoder.sv
// Event decoder behind the SFP GTX receiver: event pulses, seconds timestamp, heartbeat, dbus.
// Optional per-channel hit counters are built when SFP_EVENT_CNT_EN is defined.
module sfp_event_decoder #(
   parameter int NUM_EVENTS = 4,
   parameter int PULSE_LEN  = 4,
   parameter int HB_TIMEOUT = 8192,
   parameter int CNT_W      = 16
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [15:0]                  rxdata_i,
   input  logic [1:0]                   rxcharisk_i,
   input  logic                         rx_link_ok_i,
   input  logic [8*NUM_EVENTS-1:0]      event_code_i,
   output logic [NUM_EVENTS-1:0]        event_o,
   output logic [7:0]                   dbus_o,
   output logic [31:0]                  utime_o,
   output logic                         utime_valid_o,
   output logic                         sec_err_o,
   output logic                         heartbeat_lost_o,
   output logic [CNT_W*NUM_EVENTS-1:0]  event_cnt_o
);

   localparam int              SW           = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam logic [SW-1:0]   STRETCH_LOAD = SW'(PULSE_LEN - 1);
   localparam logic [15:0]     HB_LIMIT     = 16'(HB_TIMEOUT);
   localparam logic [7:0]      CODE_SEC0    = 8'h70;
   localparam logic [7:0]      CODE_SEC1    = 8'h71;
   localparam logic [7:0]      CODE_HB      = 8'h7A;
   localparam logic [7:0]      CODE_SEC_END = 8'h7D;
   localparam logic [5:0]      BITS_FULL    = 6'd32;
   localparam logic [5:0]      BITS_SAT     = 6'd33;

   logic                                 unused_s;
   logic [7:0]                           ev_byte_s;
   logic                                 byte_vld_s;
   logic [NUM_EVENTS-1:0]                match_s;

   logic [NUM_EVENTS-1:0][SW-1:0]        stretch_q, stretch_d;
   logic [NUM_EVENTS-1:0]                event_q, event_d;
   logic [31:0]                          shreg_q, shreg_d;
   logic [5:0]                           bitcnt_q, bitcnt_d;
   logic [31:0]                          utime_q, utime_d;
   logic                                 utime_valid_q, utime_valid_d;
   logic                                 sec_err_q, sec_err_d;
   logic [15:0]                          wd_q, wd_d;
   logic                                 hb_lost_q, hb_lost_d;
   logic [7:0]                           dbus_q, dbus_d;

   assign unused_s = rxcharisk_i[1];

   always_comb begin
      ev_byte_s  = rxdata_i[7:0];
      byte_vld_s = rx_link_ok_i & ~rxcharisk_i[0] & (ev_byte_s != 8'h00);
      match_s    = '0;
      for (int ch = 0; ch < NUM_EVENTS; ch++) begin
         match_s[ch] = byte_vld_s && (event_code_i[8*ch +: 8] == ev_byte_s)
                       && (event_code_i[8*ch +: 8] != 8'h00);
      end
   end

   // A match reloads the stretch counter, so a retrigger never leaves a gap.
   always_comb begin
      stretch_d = stretch_q;
      event_d   = event_q;
      for (int ch = 0; ch < NUM_EVENTS; ch++) begin
         if (!rx_link_ok_i) begin
            stretch_d[ch] = '0;
            event_d[ch]   = 1'b0;
         end else if (match_s[ch]) begin
            stretch_d[ch] = STRETCH_LOAD;
            event_d[ch]   = 1'b1;
         end else if (stretch_q[ch] != '0) begin
            stretch_d[ch] = stretch_q[ch] - SW'(1);
            event_d[ch]   = 1'b1;
         end else begin
            stretch_d[ch] = '0;
            event_d[ch]   = 1'b0;
         end
      end
   end

   always_comb begin
      shreg_d       = shreg_q;
      bitcnt_d      = bitcnt_q;
      utime_d       = utime_q;
      utime_valid_d = utime_valid_q;
      sec_err_d     = 1'b0;
      if (!rx_link_ok_i) begin
         shreg_d       = 32'h0;
         bitcnt_d      = 6'd0;
         utime_valid_d = 1'b0;
      end else if (byte_vld_s) begin
         case (ev_byte_s)
            CODE_SEC0, CODE_SEC1: begin
               shreg_d  = {shreg_q[30:0], ev_byte_s[0]};
               bitcnt_d = (bitcnt_q == BITS_SAT) ? BITS_SAT : bitcnt_q + 6'd1;
            end
            CODE_SEC_END: begin
               if (bitcnt_q == BITS_FULL) begin
                  utime_d       = shreg_q;
                  utime_valid_d = 1'b1;
               end else begin
                  sec_err_d = 1'b1;
               end
               shreg_d  = 32'h0;
               bitcnt_d = 6'd0;
            end
            default: begin
               shreg_d = shreg_q;
            end
         endcase
      end else begin
         shreg_d = shreg_q;
      end
   end

   // Watchdog saturates at the timeout so the lost flag cannot clear by wrapping.
   always_comb begin
      wd_d = wd_q;
      if (byte_vld_s && (ev_byte_s == CODE_HB)) begin
         wd_d = 16'h0;
      end else if (wd_q < HB_LIMIT) begin
         wd_d = wd_q + 16'd1;
      end else begin
         wd_d = wd_q;
      end
      hb_lost_d = (wd_d >= HB_LIMIT);
      dbus_d    = rx_link_ok_i ? rxdata_i[15:8] : 8'h00;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stretch_q     <= '0;
         event_q       <= '0;
         shreg_q       <= 32'h0;
         bitcnt_q      <= 6'd0;
         utime_q       <= 32'h0;
         utime_valid_q <= 1'b0;
         sec_err_q     <= 1'b0;
         wd_q          <= 16'h0;
         hb_lost_q     <= 1'b0;
         dbus_q        <= 8'h00;
      end else begin
         stretch_q     <= stretch_d;
         event_q       <= event_d;
         shreg_q       <= shreg_d;
         bitcnt_q      <= bitcnt_d;
         utime_q       <= utime_d;
         utime_valid_q <= utime_valid_d;
         sec_err_q     <= sec_err_d;
         wd_q          <= wd_d;
         hb_lost_q     <= hb_lost_d;
         dbus_q        <= dbus_d;
      end
   end

   assign event_o          = event_q;
   assign dbus_o           = dbus_q;
   assign utime_o          = utime_q;
   assign utime_valid_o    = utime_valid_q;
   assign sec_err_o        = sec_err_q;
   assign heartbeat_lost_o = hb_lost_q;

`ifdef SFP_EVENT_CNT_EN
   logic [NUM_EVENTS-1:0][CNT_W-1:0] cnt_q, cnt_d;

   // Hit counters saturate at all-ones and only reset_i clears them.
   always_comb begin
      cnt_d = cnt_q;
      for (int ch = 0; ch < NUM_EVENTS; ch++) begin
         if (match_s[ch] && (cnt_q[ch] != {CNT_W{1'b1}})) begin
            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
         end else begin
            cnt_d[ch] = cnt_q[ch];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign event_cnt_o = cnt_q;
`else
   assign event_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sfp_event_decoder.sv
// Scoreboard bench for sfp_event_decoder: directed stimulus pushes expectations, a monitor checks them.
module tb_sfp_event_decoder;

   localparam int NE  = 4;
   localparam int PL  = 4;
   localparam int HBT = 8192;
   localparam int CW  = 16;

   localparam int F_EV = 0;
   localparam int F_DB = 1;
   localparam int F_UT = 2;
   localparam int F_UV = 3;
   localparam int F_SE = 4;
   localparam int F_HB = 5;
   localparam int F_CN = 6;

   logic                 clk = 1'b0;
   logic                 reset_i;
   logic [15:0]          rxdata;
   logic [1:0]           rxk;
   logic                 link;
   logic [8*NE-1:0]      codes;
   logic [NE-1:0]        event_o;
   logic [7:0]           dbus_o;
   logic [31:0]          utime_o;
   logic                 utime_valid_o;
   logic                 sec_err_o;
   logic                 heartbeat_lost_o;
   logic [CW*NE-1:0]     event_cnt_o;

   always #5 clk = ~clk;

   sfp_event_decoder #(
      .NUM_EVENTS(NE), .PULSE_LEN(PL), .HB_TIMEOUT(HBT), .CNT_W(CW)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .rxdata_i(rxdata), .rxcharisk_i(rxk),
      .rx_link_ok_i(link), .event_code_i(codes), .event_o(event_o), .dbus_o(dbus_o),
      .utime_o(utime_o), .utime_valid_o(utime_valid_o), .sec_err_o(sec_err_o),
      .heartbeat_lost_o(heartbeat_lost_o), .event_cnt_o(event_cnt_o)
   );

   typedef struct {
      int          cyc;
      int          fld;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   int   n0    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string fname(input int f);
      case (f)
         F_EV:    return "event_o";
         F_DB:    return "dbus_o";
         F_UT:    return "utime_o";
         F_UV:    return "utime_valid_o";
         F_SE:    return "sec_err_o";
         F_HB:    return "heartbeat_lost_o";
         F_CN:    return "event_cnt_ch0";
         default: return "unknown";
      endcase
   endfunction

   function automatic logic [31:0] actual(input int f);
      case (f)
         F_EV:    return 32'(event_o);
         F_DB:    return 32'(dbus_o);
         F_UT:    return utime_o;
         F_UV:    return 32'(utime_valid_o);
         F_SE:    return 32'(sec_err_o);
         F_HB:    return 32'(heartbeat_lost_o);
         F_CN:    return 32'(event_cnt_o[CW-1:0]);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic logic [31:0] cnt_exp();
`ifdef SFP_EVENT_CNT_EN
      return 32'(n0);
`else
      return 32'h0;
`endif
   endfunction

   function automatic void push_exp(input int d, input int f, input logic [31:0] v);
      exp_t e;
      e.cyc = cyc + d;
      e.fld = f;
      e.val = v;
      sb.push_back(e);
   endfunction

   // Monitor: checks every expectation due in the current cycle, away from the active edge.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            total++;
            if ((sb[i].cyc < cyc) || (actual(sb[i].fld) !== sb[i].val)) begin
               bad++;
               $display("FAIL %s at cycle %0d (due %0d): got %h, want %h",
                        fname(sb[i].fld), cyc, sb[i].cyc, actual(sb[i].fld), sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic k, input logic [7:0] db);
      rxdata = {db, b};
      rxk    = {1'b0, k};
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(8'h00, 1'b0, 8'h00);
   endtask

   task automatic send_bits(input logic [31:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) send(val[i] ? 8'h71 : 8'h70, 1'b0, 8'h00);
   endtask

   initial begin
      reset_i = 1'b1;
      rxdata  = 16'hAB7C;
      rxk     = 2'b00;
      link    = 1'b1;
      codes   = {8'h00, 8'h55, 8'h7A, 8'h7C};
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ((event_o !== '0) || (dbus_o !== 8'h00) || (utime_o !== 32'h0) ||
          (utime_valid_o !== 1'b0) || (sec_err_o !== 1'b0) ||
          (heartbeat_lost_o !== 1'b0) || (event_cnt_o !== '0)) begin
         bad++;
         $display("FAIL reset state: ev=%h db=%h ut=%h uv=%b se=%b hb=%b cnt=%h",
                  event_o, dbus_o, utime_o, utime_valid_o, sec_err_o,
                  heartbeat_lost_o, event_cnt_o);
      end
      for (int f = F_EV; f <= F_CN; f++) push_exp(0, f, 32'h0);
      reset_i = 1'b0;
      idle(2);

      // Single event: 4-cycle pulse from the next cycle, dbus latency 1.
      n0++;
      for (int d = 1; d <= 4; d++) push_exp(d, F_EV, 32'h1);
      push_exp(5, F_EV, 32'h0);
      push_exp(1, F_DB, 32'h3C);
      push_exp(2, F_DB, 32'h0);
      push_exp(1, F_CN, cnt_exp());
      send(8'h7C, 1'b0, 8'h3C);
      idle(6);

      // Retrigger two cycles apart: 6 continuous cycles.
      n0 += 2;
      for (int d = 1; d <= 6; d++) push_exp(d, F_EV, 32'h1);
      push_exp(7, F_EV, 32'h0);
      push_exp(3, F_CN, cnt_exp());
      send(8'h7C, 1'b0, 8'h00);
      idle(1);
      send(8'h7C, 1'b0, 8'h00);
      idle(6);

      // K character does not qualify the byte.
      push_exp(1, F_EV, 32'h0);
      push_exp(2, F_EV, 32'h0);
      push_exp(2, F_CN, cnt_exp());
      send(8'h7C, 1'b1, 8'h00);
      idle(3);

      // Two channels on the same code; a code change mid-pulse does not cut it.
      codes[31:24] = 8'h7C;
      n0++;
      for (int d = 1; d <= 4; d++) push_exp(d, F_EV, 32'h9);
      push_exp(5, F_EV, 32'h0);
      send(8'h7C, 1'b0, 8'h00);
      codes[31:24] = 8'h00;
      idle(6);

      // All codes disabled: nothing fires.
      codes = '0;
      push_exp(1, F_EV, 32'h0);
      push_exp(2, F_EV, 32'h0);
      send(8'h7C, 1'b0, 8'h00);
      idle(2);
      codes = {8'h00, 8'h55, 8'h7A, 8'h7C};

      // Full 32-bit timestamp.
      send_bits(32'hA5A5_0001, 32);
      push_exp(0, F_UT, 32'h0);
      push_exp(0, F_UV, 32'h0);
      push_exp(1, F_UT, 32'hA5A5_0001);
      push_exp(1, F_UV, 32'h1);
      push_exp(1, F_SE, 32'h0);
      send(8'h7D, 1'b0, 8'h00);
      idle(2);

      // 31 bits: error pulse, timestamp held.
      send_bits(32'h7FFF_FFFF, 31);
      push_exp(1, F_SE, 32'h1);
      push_exp(2, F_SE, 32'h0);
      push_exp(1, F_UT, 32'hA5A5_0001);
      push_exp(1, F_UV, 32'h1);
      send(8'h7D, 1'b0, 8'h00);
      idle(2);

      // 33 bits: same error behaviour.
      send_bits(32'h0000_0000, 32);
      send(8'h71, 1'b0, 8'h00);
      push_exp(1, F_SE, 32'h1);
      push_exp(2, F_SE, 32'h0);
      push_exp(1, F_UT, 32'hA5A5_0001);
      send(8'h7D, 1'b0, 8'h00);
      idle(2);

      // Counter was cleared by the failed frames: next 32 bits latch.
      send_bits(32'h1234_5678, 32);
      push_exp(1, F_UT, 32'h1234_5678);
      push_exp(1, F_SE, 32'h0);
      send(8'h7D, 1'b0, 8'h00);
      idle(2);

      // Link drop mid-pulse and mid-shift.
      send_bits(32'h0000_03FF, 10);
      n0++;
      push_exp(1, F_EV, 32'h1);
      push_exp(2, F_EV, 32'h1);
      push_exp(3, F_EV, 32'h0);
      push_exp(4, F_EV, 32'h0);
      push_exp(2, F_DB, 32'h99);
      push_exp(3, F_DB, 32'h0);
      push_exp(3, F_UV, 32'h0);
      push_exp(3, F_UT, 32'h1234_5678);
      push_exp(3, F_CN, cnt_exp());
      send(8'h7C, 1'b0, 8'h00);
      send(8'h00, 1'b0, 8'h99);
      link = 1'b0;
      send(8'h7C, 1'b0, 8'h99);
      send(8'h71, 1'b0, 8'h99);
      link = 1'b1;
      idle(2);
      send_bits(32'h0F0F_F0F0, 32);
      push_exp(1, F_UT, 32'h0F0F_F0F0);
      push_exp(1, F_UV, 32'h1);
      push_exp(1, F_SE, 32'h0);
      send(8'h7D, 1'b0, 8'h00);
      idle(2);

      // Heartbeat (also a programmed reserved code on ch1), then timeout and recovery.
      push_exp(1, F_EV, 32'h2);
      push_exp(5, F_EV, 32'h0);
      push_exp(1, F_HB, 32'h0);
      push_exp(HBT, F_HB, 32'h0);
      push_exp(HBT + 1, F_HB, 32'h1);
      send(8'h7A, 1'b0, 8'h00);
      idle(HBT + 2);
      total++;
      if (heartbeat_lost_o !== 1'b1) begin
         bad++;
         $display("FAIL heartbeat watchdog did not expire after %0d idle cycles: got %b",
                  HBT + 2, heartbeat_lost_o);
      end
      push_exp(0, F_HB, 32'h1);
      push_exp(1, F_HB, 32'h0);
      send(8'h7A, 1'b0, 8'h00);
      idle(5);

      if (bad != 0) begin
         $display("FAIL test: total=%0d bad=%0d", total, bad);
      end else begin
         $display("PASS test: total=%0d bad=%0d", total, bad);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
